seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, registered successor to the combinational integer ALU in the mini-MIPS datapath. It keeps the existing 4-bit `alu_op` encoding and adds:
- true carry/overflow flags;
- a real arithmetic right shift;
- an iterative shift-add multiplier feeding a HI/LO accumulator for `mul`/`madd`/`maddu`.

It sits in EX behind a valid/ready handshake, so the pipeline stalls while a multiply is in flight.

## Interface
- `WIDTH`, 32, datapath width; power of two, 8..64
- `SHW`, `$clog2(WIDTH)`, shift-amount width (derived, do not override)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operation request
- `in_ready`  out  1  high when the block can accept (state IDLE)
- `alu_op`  in  4  operation code
- `a`, `b`  in  WIDTH  operands
- `acc_clr`  in  1  clear HI/LO; honoured only in IDLE when no op is accepted that cycle
- `out_valid`  out  1  one-cycle pulse, result/flags valid
- `result`  out  WIDTH  registered result
- `zero`  out  1  `result == 0`
- `carry_out`  out  1  carry (add) / borrow (sub), else 0
- `overflow`  out  1  signed overflow (add/sub), else 0
- `hi`, `lo`  out  WIDTH  accumulator registers, always visible

Reset is asynchronous and active-high on `rst`, single clock `clk`.

## Operation
Op codes:

| Code | Op | Code | Op |
|---|---|---|---|
| 0001 | add | 1001 | xor |
| 0010 | sub | 1010 | slt (signed) |
| 0011 | madd (signed) | 1011 | sltu |
| 0100 | maddu | 1100 | lui: `{b[WIDTH/2-1:0], 0}` |
| 0101 | mul | 1101 | sra: `$signed(b) >>> a[SHW-1:0]` |
| 0110 | and | 1110 | sll: `b << a[SHW-1:0]` |
| 0111 | or | 1111 | srl: `b >> a[SHW-1:0]` |
| 1000 | nor | 0000 | unknown: result 0, zero 1 |

- **add/sub:** computed at WIDTH+1 bits.
  - `carry_out` = bit WIDTH of `{0,a}+{0,b}`, or borrow `a<b` for sub.
  - add overflow = `a[MSB]==b[MSB] && res[MSB]!=a[MSB]`.
  - sub overflow = `a[MSB]!=b[MSB] && res[MSB]!=a[MSB]`.
- **Single-cycle ops** (all except 0011/0100/0101): accepted in IDLE, result registered, `out_valid` next cycle; state stays IDLE.
- **Multiply ops:** enter MULT.
  - Latch `|a|`, `|b|` and sign = `a[MSB]^b[MSB]` for madd. maddu and mul are unsigned.
  - Perform WIDTH radix-2 shift-add iterations into a 2·WIDTH product, one iteration per cycle.
  - Then go to FIN and negate the product if sign is set.
- **FIN:**
  - mul: `result` = product low WIDTH bits; HI/LO unchanged.
  - madd/maddu: `{hi,lo} <= {hi,lo} + product`, mod 2^(2·WIDTH); `result` = new `lo`.
  - `out_valid` pulses in the cycle after FIN; return to IDLE.
  - `carry_out` = `overflow` = 0 for multiply ops.
- **Flags on other ops:** `carry_out`, `overflow` = 0 on all non-add/sub ops; `zero` tracks the registered result for every op.
- **State machine:**
  - IDLE → MULT on an accepted multiply op.
  - MULT → MULT while the iteration counter is below WIDTH−1.
  - MULT → FIN when it reaches WIDTH−1.
  - FIN → IDLE.

## Timing
- **Reset:** all outputs 0, `in_ready` 1 once `rst` deasserts, state IDLE, counter 0.
- **Accept:** an op is taken on the edge where `in_valid && in_ready`. `in_valid` while `in_ready`=0 is ignored, not queued.
- **Latency:** single-cycle ops 1 cycle; multiply ops WIDTH+2 cycles (accept edge → `out_valid` high). `in_ready` is low for WIDTH+1 cycles.
- **Back-to-back:** single-cycle ops may issue every cycle; `out_valid` stays high continuously.
- **Output hold:** `result` and flags hold their value between pulses.
- **`acc_clr`:** takes effect at the next edge. It is ignored if asserted together with an accepted op, and ignored outside IDLE.
- **Reset mid-multiply:** aborts immediately, HI/LO cleared, no `out_valid`.
- **Operand capture:** operands are captured at accept; later changes on `a`/`b` do not affect an in-flight multiply.

## Structure
- **Package `alu_pkg`:**
  - localparams for the 16 op codes;
  - state enum `{IDLE, MULT, FIN}`;
  - function `is_mult_op(op)`.
- **Sub-module `shift_add_mult`** (parameter WIDTH):
  - `start` / `busy` / `done` interface;
  - unsigned magnitude in, 2·WIDTH product out;
  - iteration counter held internally.
- **Top level** holds the FSM, sign fix-up, HI/LO and the single-cycle datapath.

## Test plan
- **Reset:** `rst` pulse mid-madd (cycle 10) with WIDTH=32 → no `out_valid`, `hi`=`lo`=0, `in_ready`=1 on the next cycle.
- **add overflow:** a=0x7FFFFFFF, b=1 → result 0x80000000, `overflow`=1, `carry_out`=0, `out_valid` 1 cycle later.
- **add carry:** a=0xFFFFFFFF, b=1 → result 0, `zero`=1, `carry_out`=1, `overflow`=0.
- **sra:** b=0x80000000, a=4 → result 0xF8000000. Issued back-to-back with srl (same operands) → 0x08000000 on the next cycle.
- **madd:** madd a=−3 (0xFFFFFFFD), b=7 from `hi`=`lo`=0 → `{hi,lo}`=0xFFFFFFFF_FFFFFFEB, `out_valid` exactly 34 cycles after accept. A second maddu with a=0xFFFFFFFF, b=2 → `{hi,lo}`=0x00000001_FFFFFFE9 (mod 2^64).
- **mul with stall:** mul a=0x10000, b=0x10000 → result 0, `zero`=1, HI/LO unchanged. `in_valid` held during MULT is not accepted until `in_ready` rises.

Source files
------------

// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// alu_pkg : op codes, FSM state type and helpers shared by seq_alu
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_MADD  = 4'b0011;
  localparam logic [3:0] OP_MADDU = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1001;
  localparam logic [3:0] OP_SLT   = 4'b1010;
  localparam logic [3:0] OP_SLTU  = 4'b1011;
  localparam logic [3:0] OP_LUI   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_SLL   = 4'b1110;
  localparam logic [3:0] OP_SRL   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MUL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_add_mult.sv
//------------------------------------------------------------------------------
// shift_add_mult : radix-2 unsigned shift-add multiplier, one bit per cycle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_add_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;

  // done marks the cycle in which the final iteration is applied
  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign busy    = busy_q;
  assign product = prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      prod_q   <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, mcand};
      mplier_q <= mplier;
    end else if (busy_q) begin
      if (mplier_q[0]) prod_q <= prod_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
//------------------------------------------------------------------------------
// seq_alu : registered ALU with flags, shifts and iterative HI/LO multiply-accumulate
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q;
  logic [3:0]         op_q;
  logic               sign_q;
  logic               valid_q, zero_q, carry_q, ovf_q;
  logic [WIDTH-1:0]   result_q, hi_q, lo_q;

  logic [WIDTH:0]     sum_w, diff_w;
  logic [WIDTH-1:0]   res_d, mag_a, mag_b;
  logic               carry_d, ovf_d;
  logic               mult_start, mult_busy, mult_done;
  logic               signed_mac;
  logic [2*WIDTH-1:0] product, prod_fix, acc_sum;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        res_d   = sum_w[WIDTH-1:0];
        carry_d = sum_w[WIDTH];
        ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff_w[WIDTH-1:0];
        carry_d = diff_w[WIDTH];
        ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_NOR:  res_d = ~(a | b);
      OP_XOR:  res_d = a ^ b;
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, a < b};
      OP_LUI:  res_d = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SRA:  res_d = WIDTH'($signed(b) >>> a[SHW-1:0]);
      OP_SLL:  res_d = b << a[SHW-1:0];
      OP_SRL:  res_d = b >> a[SHW-1:0];
      default: res_d = '0;
    endcase
  end

  // madd multiplies magnitudes and re-applies the sign after the last iteration
  assign signed_mac = (alu_op == OP_MADD);
  assign mag_a      = (signed_mac && a[WIDTH-1]) ? -a : a;
  assign mag_b      = (signed_mac && b[WIDTH-1]) ? -b : b;
  assign mult_start = (state_q == IDLE) && in_valid && is_mult_op(alu_op);
  assign prod_fix   = sign_q ? -product : product;
  assign acc_sum    = {hi_q, lo_q} + prod_fix;

  shift_add_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .mcand   (mag_a),
    .mplier  (mag_b),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_NOP;
      sign_q   <= 1'b0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_mult_op(alu_op)) begin
              state_q <= MULT;
              op_q    <= alu_op;
              sign_q  <= signed_mac && (a[WIDTH-1] ^ b[WIDTH-1]);
            end else begin
              valid_q  <= 1'b1;
              result_q <= res_d;
              zero_q   <= (res_d == '0);
              carry_q  <= carry_d;
              ovf_q    <= ovf_d;
            end
          end else if (acc_clr) begin
            hi_q <= '0;
            lo_q <= '0;
          end
        end
        MULT: begin
          if (mult_done || !mult_busy) state_q <= FIN;
        end
        FIN: begin
          state_q <= IDLE;
          valid_q <= 1'b1;
          carry_q <= 1'b0;
          ovf_q   <= 1'b0;
          if (op_q == OP_MUL) begin
            result_q <= prod_fix[WIDTH-1:0];
            zero_q   <= (prod_fix[WIDTH-1:0] == '0);
          end else begin
            {hi_q, lo_q} <= acc_sum;
            result_q     <= acc_sum[WIDTH-1:0];
            zero_q       <= (acc_sum[WIDTH-1:0] == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
//------------------------------------------------------------------------------
// tb_seq_alu : directed vector table plus multiply / reset / acc_clr sequences
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_alu;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int NV = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         acc_clr = 1'b0;
  logic [3:0]   alu_op = 4'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, zero, carry_out, overflow;
  logic [W-1:0] result, hi, lo;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } vec_t;

  vec_t vecs[NV];

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .carry_out (carry_out),
    .overflow  (overflow),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one multiply; returns latency (edges until out_valid, accept = 1) and in_ready-low count
  task automatic mult_op(input logic [3:0] op, input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input bit hold, output int lat, output int rdy_low);
    alu_op   = op;
    a        = ma;
    b        = mb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      alu_op = OP_ADD;
      a      = 32'd1;
      b      = 32'd2;
    end else begin
      in_valid = 1'b0;
      a        = 32'hDEAD_BEEF;
      b        = 32'h1234_5678;
    end
    lat     = 1;
    rdy_low = in_ready ? 0 : 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!in_ready) rdy_low++;
    end
  endtask

  initial begin
    int lat, rl, pulses;

    vecs[0]  = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_OR,   32'h0000_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_NOR,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{OP_LUI,  32'hFFFF_FFFF, 32'hABCD_1234, 32'h1234_0000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{OP_SRA,  32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{OP_SRL,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{OP_SLL,  32'h0000_001F, 32'h0000_0003, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{OP_SLL,  32'h0000_0024, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{OP_NOP,  32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1'b0, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", 64'(result), 64'h0);
    chk("rst_flags", 64'({out_valid, zero, carry_out, overflow}), 64'h0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // single-cycle ops issued back to back
    in_valid = 1'b1;
    for (int i = 0; i < NV; i++) begin
      alu_op = vecs[i].op;
      a      = vecs[i].a;
      b      = vecs[i].b;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'h1);
      chk($sformatf("v%0d_result", i), 64'(result), 64'(vecs[i].res));
      chk($sformatf("v%0d_flags", i), 64'({zero, carry_out, overflow}),
          64'({vecs[i].z, vecs[i].c, vecs[i].v}));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold_valid", 64'(out_valid), 64'h0);
    chk("hold_result", 64'({result, zero}), 64'({32'h0, 1'b1}));

    // madd -3 * 7 into empty accumulator
    mult_op(OP_MADD, 32'hFFFF_FFFD, 32'd7, 1'b0, lat, rl);
    chk("madd_latency", 64'(lat), 64'd34);
    chk("madd_ready_low", 64'(rl), 64'd33);
    chk("madd_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("madd_result", 64'({result, carry_out, overflow}), 64'({32'hFFFF_FFEB, 2'b00}));
    @(posedge clk); #1;
    chk("madd_pulse", 64'(out_valid), 64'h0);

    // maddu wraps modulo 2^64
    mult_op(OP_MADDU, 32'hFFFF_FFFF, 32'd2, 1'b0, lat, rl);
    chk("maddu_latency", 64'(lat), 64'd34);
    chk("maddu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFE9);
    chk("maddu_result", 64'(result), 64'hFFFF_FFE9);

    // mul with in_valid held: queued add accepted only once in_ready rises
    mult_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, lat, rl);
    chk("mul_latency", 64'(lat), 64'd34);
    chk("mul_result", 64'({result, zero}), 64'({32'h0, 1'b1}));
    chk("mul_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFE9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall_add_valid", 64'(out_valid), 64'h1);
    chk("stall_add_result", 64'(result), 64'h3);

    // acc_clr together with an accepted op is ignored
    @(posedge clk); #1;
    alu_op   = OP_ADD;
    a        = 32'd2;
    b        = 32'd2;
    in_valid = 1'b1;
    acc_clr  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    chk("clr_ignored_result", 64'(result), 64'h4);
    chk("clr_ignored_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFE9);

    // reset in the middle of a madd
    alu_op   = OP_MADD;
    a        = 32'd3;
    b        = 32'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_hilo", {hi, lo}, 64'h0);
    chk("midrst_valid", 64'(out_valid), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready", 64'(in_ready), 64'h1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) pulses++;
      @(posedge clk); #1;
    end
    chk("midrst_no_pulse", 64'(pulses), 64'h0);

    // fresh maddu then a standalone acc_clr
    mult_op(OP_MADDU, 32'd3, 32'd5, 1'b0, lat, rl);
    chk("maddu2_hilo", {hi, lo}, 64'd15);
    @(posedge clk); #1;
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    chk("acc_clr_hilo", {hi, lo}, 64'h0);
    chk("acc_clr_result_hold", 64'(result), 64'd15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
